// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking layer front end.
// Default sizes come from the NUM_SPIKES / TIME_PERIOD / LOG_TIME_PERIOD macros.
`ifndef NUM_SPIKES
`define NUM_SPIKES 4
`endif
`ifndef TIME_PERIOD
`define TIME_PERIOD 8
`endif
`ifndef LOG_TIME_PERIOD
`define LOG_TIME_PERIOD 3
`endif

package snn_pkg;

  localparam int unsigned NUM_SPIKES_DEF  = `NUM_SPIKES;
  localparam int unsigned TIME_PERIOD_DEF = `TIME_PERIOD;
  localparam int unsigned TW_DEF          = `LOG_TIME_PERIOD + 1;

  typedef logic [TW_DEF-1:0] spike_time_t;

  localparam spike_time_t NO_SPIKE = spike_time_t'(TIME_PERIOD_DEF);

  typedef enum logic {FILL, FULL} fill_state_t;

endpackage

// File: rtl/spike_encoder_if.sv
// Pixel stream handshake between the pixel source and the spike encoder.
interface spike_encoder_if #(
  parameter int unsigned PIX_W = 8
);
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic             pix_last;

  modport master (output pix_valid, output pix_data, output pix_last, input pix_ready);
  modport slave  (input pix_valid, input pix_data, input pix_last, output pix_ready);
endinterface

// File: rtl/spike_time_quantizer.sv
// Combinational pixel-intensity to spike-time map; brighter pixels fire earlier.
// SPIKE_ENC_THRESHOLD_EN: pixels below SPIKE_THRESH encode no-spike.
module spike_time_quantizer
  import snn_pkg::*;
#(
  parameter int unsigned TIME_PERIOD  = TIME_PERIOD_DEF,
  parameter int unsigned TW           = TW_DEF,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned SPIKE_THRESH = 16
) (
  input  logic [PIX_W-1:0] pix_data,
  output logic [TW-1:0]    spike_time
);

  localparam int unsigned PW = PIX_W + TW;

  logic [PW-1:0] prod;
  logic [TW-1:0] quant;

  // pix * TIME_PERIOD < 2^PIX_W * TIME_PERIOD, so the shifted product fits in TW bits
  assign prod  = PW'(pix_data) * PW'(TIME_PERIOD);
  assign quant = TW'(TW'(TIME_PERIOD - 1) - TW'(prod >> PIX_W));

`ifdef SPIKE_ENC_THRESHOLD_EN
  assign spike_time = (pix_data < PIX_W'(SPIKE_THRESH)) ? TW'(TIME_PERIOD) : quant;
`else
  logic unused_thresh;
  assign unused_thresh = (SPIKE_THRESH != 0);
  assign spike_time    = quant;
`endif

endmodule

// File: rtl/spike_encoder.sv
// Double-buffered spike encoder: fills one frame of spike times while presenting the
// previous one, swapping at the time_val wrap. Option: SPIKE_ENC_THRESHOLD_EN.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_SPIKES   = `NUM_SPIKES,
  parameter int unsigned TIME_PERIOD  = `TIME_PERIOD,
  parameter int unsigned TW           = `LOG_TIME_PERIOD + 1,
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned SPIKE_THRESH = 16
) (
  input  logic                             clk,
  input  logic                             rst_l,
  input  logic [TW-1:0]                    time_val,
  spike_encoder_if.slave                   pix,
  output logic [NUM_SPIKES-1:0][TW-1:0]    spike_times,
  output logic                             frame_valid,
  output logic                             frame_start,
  output logic                             frame_err
);

  localparam int unsigned IW = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;
  localparam logic [TW-1:0] NoSpike = TW'(TIME_PERIOD);
  localparam logic [IW-1:0] LastIdx = IW'(NUM_SPIKES - 1);

  fill_state_t                      state_q, state_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [NUM_SPIKES-1:0][TW-1:0]    fill_q, fill_d, pres_q, pres_d;
  logic                             valid_q, valid_d, start_q, start_d, err_q, err_d;
  logic [TW-1:0]                    pix_time;
  logic                             accept, swap, at_last;

  spike_time_quantizer #(
    .TIME_PERIOD  (TIME_PERIOD),
    .TW           (TW),
    .PIX_W        (PIX_W),
    .SPIKE_THRESH (SPIKE_THRESH)
  ) u_quant (
    .pix_data   (pix.pix_data),
    .spike_time (pix_time)
  );

  assign pix.pix_ready = rst_l && (state_q == FILL);
  assign accept        = pix.pix_valid && pix.pix_ready;
  assign swap          = (time_val == TW'(TIME_PERIOD - 1));
  assign at_last       = (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fill_d  = fill_q;
    pres_d  = pres_q;
    valid_d = valid_q;
    start_d = 1'b0;
    err_d   = 1'b0;

    // Swap only moves a FULL buffer, accept needs FILL: the two never collide.
    if (swap) begin
      if (state_q == FULL) begin
        pres_d  = fill_q;
        valid_d = 1'b1;
        start_d = 1'b1;
        state_d = FILL;
        idx_d   = '0;
      end else begin
        for (int i = 0; i < NUM_SPIKES; i++) pres_d[i] = NoSpike;
        valid_d = 1'b0;
      end
    end

    if (accept) begin
      fill_d[idx_q] = pix_time;
      if (at_last || pix.pix_last) begin
        state_d = FULL;
        err_d   = !(at_last && pix.pix_last);
        for (int i = 0; i < NUM_SPIKES; i++) begin
          if (IW'(i) > idx_q) fill_d[i] = NoSpike;
        end
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= FILL;
      idx_q   <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_SPIKES; i++) begin
        fill_q[i] <= NoSpike;
        pres_q[i] <= NoSpike;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      start_q <= start_d;
      err_q   <= err_d;
      fill_q  <= fill_d;
      pres_q  <= pres_d;
    end
  end

  assign spike_times = pres_q;
  assign frame_valid = valid_q;
  assign frame_start = start_q;
  assign frame_err   = err_q;

endmodule
